// File: rtl/accumulator_drain.sv
// accumulator_drain: snapshots M accumulator sums, rescales each (>>> FRAC, saturate to DW bits)
// and streams them out over valid/ready. Build macro ACC_DRAIN_RELU_EN adds a ReLU after saturation.
module accumulator_drain #(
  parameter int DW   = 16,
  parameter int M    = 5,
  parameter int FRAC = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [2*DW-1:0]      acc_in [0:M-1][0:0],
  output logic signed [DW-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(M)-1:0]        out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        acc_enable_ok
);

  localparam int IW = $clog2(M);

  typedef logic signed [DW-1:0]   data_type;
  typedef logic signed [2*DW-1:0] double_data_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam double_data_type SAT_MAX  = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam double_data_type SAT_MIN  = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [IW-1:0]   LAST_IDX = IW'(M-1);

  // Floor shift, clamp to the narrow range, then optionally drop negatives.
  function automatic data_type scale(input double_data_type x);
    double_data_type sh;
    data_type        r;
    sh = x >>> FRAC;
    if (sh > SAT_MAX) begin
      r = SAT_MAX[DW-1:0];
    end else if (sh < SAT_MIN) begin
      r = SAT_MIN[DW-1:0];
    end else begin
      r = sh[DW-1:0];
    end
`ifdef ACC_DRAIN_RELU_EN
    if (r[DW-1]) begin
      r = {DW{1'b0}};
    end else begin
      r = r;
    end
`endif
    return r;
  endfunction

  state_t          state_r;
  double_data_type snap_r [0:M-1];
  double_data_type sel_s;

  // Output element is a plain mux of the frozen snapshot followed by the rescale.
  always_comb begin
    sel_s    = snap_r[out_index];
    out_data = scale(sel_s);
    out_last = (state_r == SEND) && (out_index == LAST_IDX);
  end

  // Drain FSM: snapshot on start, hand out one lane per handshake, pulse done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      out_valid     <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      acc_enable_ok <= 1'b1;
      out_index     <= {IW{1'b0}};
      for (int i = 0; i < M; i++) begin
        snap_r[i] <= {(2*DW){1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < M; i++) begin
              snap_r[i] <= acc_in[i][0];
            end
            out_index     <= {IW{1'b0}};
            out_valid     <= 1'b1;
            busy          <= 1'b1;
            acc_enable_ok <= 1'b0;
            state_r       <= SEND;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (out_index == LAST_IDX) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state_r   <= DONE;
            end else begin
              out_index <= out_index + IW'(1);
            end
          end
        end
        DONE: begin
          done          <= 1'b0;
          busy          <= 1'b0;
          acc_enable_ok <= 1'b1;
          state_r       <= IDLE;
        end
        default: begin
          state_r       <= IDLE;
          out_valid     <= 1'b0;
          done          <= 1'b0;
          busy          <= 1'b0;
          acc_enable_ok <= 1'b1;
          out_index     <= {IW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_drain.sv
// Directed bench for accumulator_drain (DW=16, M=5, FRAC=8); expected values worked out by hand.
module tb_accumulator_drain;

  localparam int DW   = 16;
  localparam int M    = 5;
  localparam int FRAC = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              out_ready;
  logic signed [31:0] acc_in [0:M-1][0:0];
  logic [15:0]       out_data;
  logic              out_valid;
  logic [2:0]        out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              acc_enable_ok;

  logic [15:0] exp_data [0:M-1];
  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  accumulator_drain #(.DW(DW), .M(M), .FRAC(FRAC)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .acc_in(acc_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .acc_enable_ok(acc_enable_ok)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_lanes(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] a3, input logic [31:0] a4);
    acc_in[0][0] = a0;
    acc_in[1][0] = a1;
    acc_in[2][0] = a2;
    acc_in[3][0] = a3;
    acc_in[4][0] = a4;
  endtask

  task automatic set_exp(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                         input logic [15:0] e3, input logic [15:0] e4);
    exp_data[0] = e0;
    exp_data[1] = e1;
    exp_data[2] = e2;
    exp_data[3] = e3;
    exp_data[4] = e4;
  endtask

  // Expects SEND at index 0; drains with ready high, start held for the first hold_start edges.
  task automatic drain_check(input string tag, input int hold_start);
    for (int k = 0; k < M; k++) begin
      check_eq($sformatf("%s valid%0d", tag, k), out_valid, 1);
      check_eq($sformatf("%s data%0d", tag, k), out_data, exp_data[k]);
      check_eq($sformatf("%s index%0d", tag, k), out_index, k);
      check_eq($sformatf("%s last%0d", tag, k), out_last, (k == M - 1));
      check_eq($sformatf("%s enok%0d", tag, k), acc_enable_ok, 0);
      check_eq($sformatf("%s done%0d", tag, k), done, 0);
      start     = (k < hold_start);
      out_ready = 1'b1;
      tick();
    end
    start = 1'b0;
    check_eq({tag, " done pulse"}, done, 1);
    check_eq({tag, " valid after"}, out_valid, 0);
    check_eq({tag, " busy in done"}, busy, 1);
    tick();
    check_eq({tag, " done cleared"}, done, 0);
    check_eq({tag, " busy idle"}, busy, 0);
    check_eq({tag, " enok idle"}, acc_enable_ok, 1);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    set_lanes(32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    tick();
    tick();
    check_eq("rst valid", out_valid, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst enok", acc_enable_ok, 1);
    check_eq("rst index", out_index, 0);
    check_eq("rst data", out_data, 16'h0000);
    reset = 1'b1;
    tick();
    check_eq("idle valid", out_valid, 0);

    // Straight drain
    set_lanes(32'h0000_0300, 32'h0000_0100, 32'h0000_0000, 32'h0000_7F00, 32'h0000_0080);
    set_exp(16'h0003, 16'h0001, 16'h0000, 16'h007F, 16'h0000);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    drain_check("straight", 0);

    // Saturation, floor and sign handling
    set_lanes(32'h0100_0000, 32'hFF00_0000, 32'hFFFF_FE80, 32'h0000_7FFF, 32'hFFFF_FFFF);
`ifdef ACC_DRAIN_RELU_EN
    set_exp(16'h7FFF, 16'h0000, 16'h0000, 16'h007F, 16'h0000);
`else
    set_exp(16'h7FFF, 16'h8000, 16'hFFFE, 16'h007F, 16'hFFFF);
`endif
    start = 1'b1;
    tick();
    drain_check("sat", 0);

    // Backpressure: ready alternates 0,1
    set_lanes(32'h0000_0300, 32'h0000_0100, 32'h0000_0000, 32'h0000_7F00, 32'h0000_0080);
    set_exp(16'h0003, 16'h0001, 16'h0000, 16'h007F, 16'h0000);
    start     = 1'b1;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < M; k++) begin
      out_ready = 1'b0;
      tick();
      check_eq($sformatf("bp hold valid%0d", k), out_valid, 1);
      check_eq($sformatf("bp hold data%0d", k), out_data, exp_data[k]);
      check_eq($sformatf("bp hold index%0d", k), out_index, k);
      check_eq($sformatf("bp hold done%0d", k), done, 0);
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check_eq("bp done pulse", done, 1);
    check_eq("bp valid after", out_valid, 0);
    tick();
    check_eq("bp done cleared", done, 0);
    check_eq("bp busy idle", busy, 0);

    // Snapshot isolation and start while busy
    set_lanes(32'h0000_0300, 32'h0000_0100, 32'h0000_0000, 32'h0000_7F00, 32'h0000_0080);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    set_lanes(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    drain_check("iso", 3);
    tick();
    check_eq("iso no redrain valid", out_valid, 0);
    check_eq("iso no redrain busy", busy, 0);

    // Reset in the middle of a drain
    set_lanes(32'h0100_0000, 32'hFF00_0000, 32'hFFFF_FE80, 32'h0000_7FFF, 32'hFFFF_FFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("mid index before rst", out_index, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("mid rst valid", out_valid, 0);
    check_eq("mid rst busy", busy, 0);
    check_eq("mid rst index", out_index, 0);
    check_eq("mid rst enok", acc_enable_ok, 1);
    check_eq("mid rst data", out_data, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("mid rst no done%0d", k), done, 0);
      tick();
    end
    set_lanes(32'h0000_0300, 32'h0000_0100, 32'h0000_0000, 32'h0000_7F00, 32'h0000_0080);
    set_exp(16'h0003, 16'h0001, 16'h0000, 16'h007F, 16'h0000);
    start = 1'b1;
    tick();
    drain_check("after rst", 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_drain.md
Name: accumulator_drain

Overview:
- Read side of the sequential accumulator bank.
- On `start`, snapshots all M `double_data_type` accumulator sums and rescales each one to `data_type` by shifting and saturating.
- Streams the results out one element per handshake, over a valid/ready interface, to the next layer or the activation stage.
- Drives `acc_enable_ok` low while draining, so the upstream controller freezes accumulation.

Parameters:
- M, 5, number of accumulator lanes (neurons); must be ≥ 2.
- FRAC, 8, arithmetic right-shift applied to each sum before narrowing (fixed-point product alignment); 0 ≤ FRAC < width of `double_data_type`.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- start  input  1  request to snapshot `acc_in` and begin draining; honoured only in IDLE.
- acc_in  input  `double_data_type` [0:M-1][0:0]  accumulator sums, same array shape as the accumulator output.
- out_data  output  `data_type`  rescaled, saturated element.
- out_valid  output  1  `out_data` is valid.
- out_ready  input  1  downstream accepts `out_data`.
- out_index  output  $clog2(M)  lane number of the current `out_data`.
- out_last  output  1  current element is lane M-1.
- busy  output  1  high when not in IDLE.
- done  output  1  one-cycle pulse after the final transfer.
- acc_enable_ok  output  1  equals `!busy`; upstream gates the accumulator enable with it.

Behaviour:
- Reset (reset==0 at posedge), from any state including mid-drain:
  - state goes to IDLE.
  - `out_valid`, `done` and `busy` are 0; `acc_enable_ok` is 1.
  - `out_index` and `out_data` are 0; the snapshot registers are cleared to 0.
  - Any element in flight is discarded.
- Widths: `data_type` is DW-bit signed and `double_data_type` is 2*DW-bit signed, both as defined in typedef.vh.
- States:
  - IDLE: `out_valid`=0. If `start`=1 at posedge, all M `acc_in` lanes are registered into snapshot regs, `out_index`←0, and the state goes to SEND.
  - SEND: `out_valid`=1 and `out_data` = scale(snap[out_index]).
    - Transfer occurs at a posedge with `out_valid` & `out_ready`.
    - On transfer with `out_index` < M-1: `out_index` increments.
    - On transfer with `out_index` == M-1: state goes to DONE.
    - With no transfer, `out_data`, `out_index` and `out_valid` hold stable (AXI-style: valid never drops without a transfer).
  - DONE: `done`=1 for exactly one cycle and `out_valid`=0; the next state is IDLE unconditionally.
- Latency:
  - First `out_valid` is asserted the cycle after `start` is sampled.
  - With `out_ready` held high, the M transfers take M consecutive cycles.
  - `done` follows in the next cycle, and `start` is accepted again one cycle after that.
- `start` while busy (SEND or DONE) is ignored; no queueing.
- `acc_in` changes after the snapshot have no effect on the current drain.
- scale(x), applied in this order:
  - Arithmetic right shift by FRAC, i.e. floor; truncation toward −∞, no rounding.
  - Saturate to the `data_type` range [−2^(DW−1), 2^(DW−1)−1].
- `out_index` is a registered value; `out_data` and `out_last` are combinational from the snapshot regs and `out_index`, with a mux-only path.
- `out_last` = (state==SEND) && (`out_index`==M−1).

Optional Feature:
- Macro: ACC_DRAIN_RELU_EN.
- Defined: scale(x) has a ReLU step after saturation: negative results become 0, non-negative results pass unchanged.
- Not defined: signed saturated values pass through, negatives included.
- All other timing and handshake behaviour is identical in both builds.

Test Plan:
- Bench config for all scenarios: DW=16, M=5, FRAC=8.
- Straight drain:
  - Stimulus: `acc_in` = {0x300, 0x100, 0x0, 0x7F00, 0x80}; pulse `start`; `out_ready`=1.
  - Required: `out_data` 0x0003, 0x0001, 0x0000, 0x007F, 0x0000 on 5 consecutive cycles; `out_last` only on the 5th; `done` on the next cycle; `acc_enable_ok`=0 throughout.
- Saturation and floor:
  - Stimulus: lane0 = 0x0100_0000; lane1 = 0xFF00_0000 (negative, large); lane2 = −384.
  - Required: 0x7FFF, 0x8000, 0xFFFE (−2). With ACC_DRAIN_RELU_EN defined: 0x7FFF, 0x0000, 0x0000.
- Backpressure:
  - Stimulus: `out_ready` alternates 0,1 starting at 0.
  - Required: each element is held for 2 cycles with `out_data`/`out_index` stable while ready=0; exactly 5 transfers; `done` one cycle after the 5th.
- Snapshot isolation and start-while-busy:
  - Stimulus: change all `acc_in` lanes to 0x7FFF_FFFF and pulse `start` again during SEND.
  - Required: the outputs still reflect the original snapshot, and after `done` the block returns to IDLE with no second drain.
- Reset mid-drain:
  - Stimulus: assert reset=0 for one posedge after 2 transfers.
  - Required: next cycle `out_valid`=0, `busy`=0, `out_index`=0, `done` never pulses; a fresh `start` then drains all 5 lanes from index 0.
